// File: rtl/mux_stream_pkg.sv
// Shared types and grant helpers for the two-channel packet stream arbiter.
package mux_stream_pkg;

  typedef enum logic {ST_IDLE, ST_LOCK} arb_state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Round-robin pick: the pointer wins a tie, otherwise whichever channel is valid.
  function automatic logic rr_pick(input logic ptr, input logic v0, input logic v1);
    if (v0 && v1) return ptr;
    return v1 ? CH1 : CH0;
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// One-entry output register; loads a beat on a transfer, drops valid on an empty load.
module mux_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_i,
  input  logic              xfer_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q, last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (ld_i) begin
      valid_q <= xfer_i;
      if (xfer_i) begin
        data_q <= data_i;
        last_q <= last_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/mux_stream_arbiter.sv
// Packet-granular two-channel arbiter with registered output and over-length guard.
// Define MUX_STREAM_ARB_STRICT_PRIO_EN to make channel 0 always win ties.
module mux_stream_arbiter
  import mux_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din_0,
  input  logic              din_0_valid,
  input  logic              din_0_last,
  output logic              din_0_ready,
  input  logic [DATA_W-1:0] din_1,
  input  logic              din_1_valid,
  input  logic              din_1_last,
  output logic              din_1_ready,
  output logic [DATA_W-1:0] mux_out,
  output logic              mux_out_valid,
  output logic              mux_out_last,
  input  logic              mux_out_ready,
  output logic              sel,
  output logic              busy,
  output logic              err_overlen
);

  arb_state_t       state_q, state_d;
  logic             sel_q, sel_d;
  logic             ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ld, xfer, grant;
  logic             cur_valid, cur_last;
  logic [DATA_W-1:0] cur_data;

  assign ld        = !mux_out_valid || mux_out_ready;
  assign cur_valid = sel_q ? din_1_valid : din_0_valid;
  assign cur_last  = sel_q ? din_1_last  : din_0_last;
  assign cur_data  = sel_q ? din_1       : din_0;
  assign cnt_inc   = cnt_q + 1'b1;

`ifdef MUX_STREAM_ARB_STRICT_PRIO_EN
  assign grant = din_0_valid ? CH0 : CH1;
`else
  assign grant = rr_pick(ptr_q, din_0_valid, din_1_valid);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= CH0;
      ptr_q   <= CH0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    xfer        = 1'b0;
    din_0_ready = 1'b0;
    din_1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din_0_valid || din_1_valid) begin
          sel_d   = grant;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        din_0_ready = ld && (sel_q == CH0);
        din_1_ready = ld && (sel_q == CH1);
        if (ld && cur_valid) begin
          xfer  = 1'b1;
          cnt_d = cnt_inc;
          // Forced release leaves the tail of the packet to re-arbitrate as a new one.
          if (cur_last || cnt_inc == CNT_W'(MAX_BEATS)) begin
            state_d = ST_IDLE;
            ptr_d   = ~sel_q;
            cnt_d   = '0;
            if (!cur_last) err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mux_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk     (clk),
    .reset   (reset),
    .ld_i    (ld),
    .xfer_i  (xfer),
    .data_i  (cur_data),
    .last_i  (cur_last),
    .data_o  (mux_out),
    .valid_o (mux_out_valid),
    .last_o  (mux_out_last)
  );

  assign sel         = sel_q;
  assign busy        = (state_q == ST_LOCK);
  assign err_overlen = err_q;

endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Scoreboard bench for mux_stream_arbiter: expected beat order is queued at stimulus time.
module tb_mux_stream_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

`ifdef MUX_STREAM_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_0 = '0, din_1 = '0;
  logic       din_0_valid = 1'b0, din_0_last = 1'b0, din_0_ready;
  logic       din_1_valid = 1'b0, din_1_last = 1'b0, din_1_ready;
  logic [7:0] mux_out;
  logic       mux_out_valid, mux_out_last;
  logic       mux_out_ready;
  logic       sel, busy, err_overlen;

  beat_t src0[$], src1[$], sb[$];
  logic  acc0 = 1'b0, acc1 = 1'b0;
  int    n_vec = 0, n_err = 0;

  mux_stream_arbiter #(.DATA_W(8), .MAX_BEATS(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .din_0(din_0), .din_0_valid(din_0_valid), .din_0_last(din_0_last), .din_0_ready(din_0_ready),
    .din_1(din_1), .din_1_valid(din_1_valid), .din_1_last(din_1_last), .din_1_ready(din_1_ready),
    .mux_out(mux_out), .mux_out_valid(mux_out_valid), .mux_out_last(mux_out_last),
    .mux_out_ready(mux_out_ready), .sel(sel), .busy(busy), .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    return b;
  endfunction

  // Source drivers: handshake sampled mid-cycle, queue advanced just after the edge.
  always @(negedge clk) begin
    acc0 = din_0_valid && din_0_ready;
    acc1 = din_1_valid && din_1_ready;
  end

  always @(posedge clk) begin
    #1;
    if (acc0 && src0.size() > 0) void'(src0.pop_front());
    if (acc1 && src1.size() > 0) void'(src1.pop_front());
    acc0 = 1'b0;
    acc1 = 1'b0;
    din_0_valid = src0.size() > 0;
    din_0       = (src0.size() > 0) ? src0[0].d : 8'h00;
    din_0_last  = (src0.size() > 0) ? src0[0].l : 1'b0;
    din_1_valid = src1.size() > 0;
    din_1       = (src1.size() > 0) ? src1[0].d : 8'h00;
    din_1_last  = (src1.size() > 0) ? src1[0].l : 1'b0;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!reset && mux_out_valid && mux_out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL extra_beat observed=%0h expected=none", mux_out);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_beat", {23'd0, mux_out_last, mux_out}, {23'd0, e.l, e.d});
      end
    end
  end

  task automatic wait_drain(input int budget, output int bcyc, output int s1cyc);
    bit done = 0;
    bcyc  = 0;
    s1cyc = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (busy && sel) s1cyc++;
      if (sb.size() == 0 && src0.size() == 0 && src1.size() == 0 && !busy && !mux_out_valid)
        done = 1;
    end
    if (!done) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_out(input logic [7:0] d);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mux_out_valid && mux_out === d) found = 1;
    end
    if (!found) chk("wait_out_timeout", {24'd0, mux_out}, {24'd0, d});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  {24'd0, mux_out}, 32'd0);
    chk({tag, "_ctl"},   {26'd0, mux_out_valid, mux_out_last, sel, busy, err_overlen, 1'b0}, 32'd0);
    chk({tag, "_ready"}, {30'd0, din_0_ready, din_1_ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    src0.delete(); src1.delete(); sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int bc, s1;
  logic [7:0] held;

  initial begin
    reset = 1'b1;
    mux_out_ready = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single 3-beat ch0 packet: 3 busy cycles, never on ch1.
    src0.push_back(mk(8'h11, 0)); src0.push_back(mk(8'h22, 0)); src0.push_back(mk(8'h33, 1));
    sb.push_back(mk(8'h11, 0));   sb.push_back(mk(8'h22, 0));   sb.push_back(mk(8'h33, 1));
    wait_drain(100, bc, s1);
    chk("t1_busy_cycles", 32'(bc), 32'd3);
    chk("t1_sel1_cycles", 32'(s1), 32'd0);

    // Pointer now at ch1: simultaneous request serves ch1 first (round-robin).
    src0.push_back(mk(8'hA0, 0)); src0.push_back(mk(8'hA1, 1));
    src1.push_back(mk(8'hB0, 0)); src1.push_back(mk(8'hB1, 1));
    if (STRICT) begin
      sb.push_back(mk(8'hA0, 0)); sb.push_back(mk(8'hA1, 1));
      sb.push_back(mk(8'hB0, 0)); sb.push_back(mk(8'hB1, 1));
    end else begin
      sb.push_back(mk(8'hB0, 0)); sb.push_back(mk(8'hB1, 1));
      sb.push_back(mk(8'hA0, 0)); sb.push_back(mk(8'hA1, 1));
    end
    wait_drain(100, bc, s1);
    chk("t2a_busy_cycles", 32'(bc), 32'd4);

    // After reset the pointer favours ch0.
    do_reset();
    src0.push_back(mk(8'hA2, 0)); src0.push_back(mk(8'hA3, 1));
    src1.push_back(mk(8'hB2, 0)); src1.push_back(mk(8'hB3, 1));
    sb.push_back(mk(8'hA2, 0)); sb.push_back(mk(8'hA3, 1));
    sb.push_back(mk(8'hB2, 0)); sb.push_back(mk(8'hB3, 1));
    wait_drain(100, bc, s1);
    chk("t2b_sel1_cycles", 32'(s1), 32'd2);

    // Backpressure mid-packet.
    for (int i = 0; i < 4; i++) begin
      src0.push_back(mk(8'h40 + 8'(i), i == 3));
      sb.push_back(mk(8'h40 + 8'(i), i == 3));
    end
    wait_out(8'h41);
    @(posedge clk); #1;
    mux_out_ready = 1'b0;
    @(negedge clk);
    held = mux_out;
    chk("bp_valid", {31'd0, mux_out_valid}, 32'd1);
    chk("bp_ready0", {31'd0, din_0_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {23'd0, mux_out_valid, mux_out}, {23'd1, held});
      chk("bp_ready0", {31'd0, din_0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    mux_out_ready = 1'b1;
    wait_drain(100, bc, s1);

    // Over-length ch1 packet; ch0 arrives mid-packet and is served after the forced release.
    for (int i = 0; i < 16; i++) sb.push_back(mk(8'h80 + 8'(i), 0));
    sb.push_back(mk(8'hC0, 0)); sb.push_back(mk(8'hC1, 1));
    sb.push_back(mk(8'h90, 1));
    for (int i = 0; i < 17; i++) src1.push_back(mk(8'h80 + 8'(i), i == 16));
    wait_out(8'h80);
    chk("ovl_err_before", {31'd0, err_overlen}, 32'd0);
    chk("ovl_sel", {31'd0, sel}, 32'd1);
    src0.push_back(mk(8'hC0, 0)); src0.push_back(mk(8'hC1, 1));
    wait_drain(300, bc, s1);
    chk("ovl_err_after", {31'd0, err_overlen}, 32'd1);

    // Reset in the middle of a 4-beat packet.
    for (int i = 0; i < 4; i++) begin
      src0.push_back(mk(8'h50 + 8'(i), i == 3));
      sb.push_back(mk(8'h50 + 8'(i), i == 3));
    end
    wait_out(8'h51);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    src0.delete(); src1.delete(); sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("postrst_valid", {31'd0, mux_out_valid}, 32'd0);
    src1.push_back(mk(8'h99, 1));
    sb.push_back(mk(8'h99, 1));
    wait_drain(100, bc, s1);
    chk("postrst_sel1_cycles", 32'(s1), 32'd1);
    chk("postrst_err", {31'd0, err_overlen}, 32'd0);

    // Both channels kept busy: round-robin alternates, strict priority starves ch1.
    for (int i = 0; i < 3; i++) src0.push_back(mk(8'hE0 + 8'(i), 1));
    src1.push_back(mk(8'hF0, 1));
    if (STRICT) begin
      sb.push_back(mk(8'hE0, 1)); sb.push_back(mk(8'hE1, 1)); sb.push_back(mk(8'hE2, 1));
      sb.push_back(mk(8'hF0, 1));
    end else begin
      sb.push_back(mk(8'hE0, 1)); sb.push_back(mk(8'hF0, 1));
      sb.push_back(mk(8'hE1, 1)); sb.push_back(mk(8'hE2, 1));
    end
    wait_drain(100, bc, s1);
    chk("t6_busy_cycles", 32'(bc), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_stream_arbiter.md
Name: mux_stream_arbiter

Overview:
- Upstream companion to the 2:1 select mux. Arbitrates two valid/ready packet streams (din_0, din_1) and drives the `sel` that steers them.
- Presents the selected beat through a one-stage registered output toward the downstream consumer.
- Round-robin at packet granularity: the grant is held from the first beat to the `last` beat, so packets never interleave.

Parameters:
- DATA_W, 8, width of each data beat.
- MAX_BEATS, 16, maximum beats per packet before forced release.
- CNT_W, 5, beat-counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din_0  input  DATA_W  channel 0 data.
- din_0_valid  input  1  channel 0 beat valid.
- din_0_last  input  1  channel 0 final beat of packet.
- din_0_ready  output  1  channel 0 beat accepted this cycle.
- din_1  input  DATA_W  channel 1 data.
- din_1_valid  input  1  channel 1 beat valid.
- din_1_last  input  1  channel 1 final beat of packet.
- din_1_ready  output  1  channel 1 beat accepted this cycle.
- mux_out  output  DATA_W  registered output data.
- mux_out_valid  output  1  output beat valid.
- mux_out_last  output  1  output final beat.
- mux_out_ready  input  1  downstream accepts the output beat.
- sel  output  1  current grant: 0 selects din_0, 1 selects din_1.
- busy  output  1  high while in the LOCK state.
- err_overlen  output  1  sticky flag: a packet hit MAX_BEATS without `last`.

Behaviour:
- Interface: one clock (`clk`). Reset (`reset`) is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State = IDLE, round-robin pointer = 0 (channel 0 preferred), beat counter = 0.
- Load enable: ld = !mux_out_valid || mux_out_ready.
- IDLE state:
  - din_x_ready = 0.
  - If either channel is valid, register the grant and go to LOCK next cycle. No beat is accepted in IDLE.
  - Grant choice: the channel equal to the pointer if it is valid, otherwise the other valid channel.
  - Both channels valid: the pointer decides.
- LOCK state:
  - din_sel_ready = ld. The ungranted channel's ready = 0.
  - A transfer occurs when din_sel_valid && din_sel_ready. It loads mux_out, mux_out_last and mux_out_valid = 1, and increments the beat counter.
  - If ld is high and there is no transfer, mux_out_valid <= 0.
- Release:
  - Triggered by a transferred beat with `last` = 1, or by the counter reaching MAX_BEATS on that transfer.
  - Next state = IDLE, pointer <= ~sel, counter <= 0.
  - Forced release (counter reached MAX_BEATS without `last`): set err_overlen (sticky until reset). The remainder of that packet re-arbitrates as a new packet.
- `sel` and `busy` change only on the IDLE->LOCK and LOCK->IDLE transitions.
- Latency: 1 cycle from input transfer to mux_out_valid.
- Throughput: an N-beat packet occupies N+1 cycles when mux_out_ready is held high (one IDLE arbitration bubble).
- Backpressure:
  - While mux_out_valid && !mux_out_ready, the output register holds, din ready = 0, and the state holds.
  - Input valid dropping mid-packet: the grant is held with no timeout.
- Asynchronous reset mid-packet: all state is discarded immediately. No partial beat is emitted after reset releases.

Optional Feature:
- Macro MUX_STREAM_ARB_STRICT_PRIO_EN.
- When defined: the pointer is ignored and channel 0 always wins when both channels are valid in IDLE. Grant hold per packet and err_overlen are unchanged.
- When undefined: round-robin as specified above.

Decomposition:
- Shared package mux_stream_pkg holds:
  - typedef enum logic {ST_IDLE, ST_LOCK} arb_state_t;
  - localparam CH0 = 1'b0, CH1 = 1'b1.
- One natural sub-module: mux_out_reg, the one-entry output register with valid/ready and load enable. Arbitration FSM and beat counter stay in the top.

Test Plan:
- Single packet: ch0 sends 3 beats (0x11, 0x22, 0x33 with last), ready always high -> sel = 0, outputs appear cycles 2-4, busy high 3 cycles, pointer = 1 after.
- Simultaneous packets: both channels request after reset, 2-beat packets -> ch0 packet completes first, then ch1. A second simultaneous request then goes to ch1 first.
- Backpressure: mux_out_ready low for 4 cycles mid-packet -> mux_out holds the same beat, din_0_ready = 0, no beat is lost or duplicated.
- Overlength: ch1 sends 16 beats with no last, MAX_BEATS = 16 -> err_overlen = 1 after the 16th beat, FSM returns to IDLE, pending ch0 is served next.
- Reset mid-packet: assert reset after beat 2 of 4 -> all outputs are 0 immediately. After release, a new ch1 packet is granted with pointer = 0 rules.
- STRICT_PRIO_EN build: both channels continuously valid -> ch0 granted every arbitration and ch1 is starved.
